// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, frame-length helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Pop-to-pop period of back-to-back frames, including the single idle cycle.
    function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                        input int parity_en, input int stop_bits);
        return (1 + data_bits + parity_en + stop_bits) * clks_per_bit + 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps, held at 0 while clear_i is high.
// Latency: tick_o is combinational from the count register.
// Backpressure: none; free-running unless cleared.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining a FIFO: pops a word when idle, sends start/data(LSB first)/parity/stop.
// Latency: start bit appears on tx_o one cycle after the pop cycle.
// Backpressure: pops only while idle and the FIFO is non-empty; empty mid-frame is ignored.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_BITS-1:0] fifo_rdata_i,
    output logic                 fifo_read_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // One bit wider than strictly needed so the index also covers the stop-bit count.
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 pop;
    logic                 done;

    assign pop = (state_q == IDLE) && !fifo_empty_i && !reset_i;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        bit_d    = bit_q;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d  = fifo_rdata_i;
                    parity_d = (^fifo_rdata_i) ^ (PARITY_ODD != 0);
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so tx_o is a clean register output.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
        end
    end

    assign fifo_read_o = pop;
    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done && !reset_i;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: an 8N1 instance and an 8O2 instance, both at 4 clocks per bit.
module tb_uart_fifo_tx;

    typedef struct {
        int   off;
        logic tx;
        logic busy;
        logic done;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_mem [16];
    logic [7:0] b_mem [16];
    int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;

    logic a_empty, a_read, a_tx, a_busy, a_done;
    logic b_empty, b_read, b_tx, b_busy, b_done;
    logic [7:0] a_rdata, b_rdata;

    assign a_empty = (a_rd == a_wr);
    assign b_empty = (b_rd == b_wr);
    assign a_rdata = a_mem[a_rd % 16];
    assign b_rdata = b_mem[b_rd % 16];

    always @(posedge clk) begin
        if (a_read) a_rd <= a_rd + 1;
        if (b_read) b_rd <= b_rd + 1;
    end

    uart_fifo_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .reset_i(reset), .fifo_empty_i(a_empty), .fifo_rdata_i(a_rdata),
        .fifo_read_o(a_read), .tx_o(a_tx), .busy_o(a_busy), .done_o(a_done));

    uart_fifo_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .fifo_empty_i(b_empty), .fifo_rdata_i(b_rdata),
        .fifo_read_o(b_read), .tx_o(b_tx), .busy_o(b_busy), .done_o(b_done));

    int errors = 0;
    int checks = 0;

    logic tr_tx [256];
    logic tr_busy [256];
    logic tr_done [256];
    logic tr_rd [256];

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input bit sel, input logic [7:0] d);
        if (sel) begin b_mem[b_wr % 16] = d; b_wr++; end
        else begin a_mem[a_wr % 16] = d; a_wr++; end
    endtask

    task automatic wait_pop(input bit sel, input string name);
        int n = 0;
        #1;
        while (!(sel ? b_read : a_read) && n < 400) begin
            step();
            n++;
        end
        chk({name, "_pop_seen"}, 32'(sel ? b_read : a_read), 32'd1);
    endtask

    // Offset 0 is the pop cycle; each step is one clock.
    task automatic record(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            tr_tx[i]   = sel ? b_tx : a_tx;
            tr_busy[i] = sel ? b_busy : a_busy;
            tr_done[i] = sel ? b_done : a_done;
            tr_rd[i]   = sel ? b_read : a_read;
            step();
        end
    endtask

    function automatic logic [7:0] decode(input int base);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = tr_tx[base + 6 + 4 * k];
        return d;
    endfunction

    function automatic int high_run(input int from, input int lim);
        int n = 0;
        while (from + n < lim && tr_tx[from + n] === 1'b1) n++;
        return n;
    endfunction

    function automatic int next_pop(input int from, input int lim);
        for (int i = from; i < lim; i++) if (tr_rd[i] === 1'b1) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int pops;
        // 0x55 frame at 4 clocks/bit: bit centres at 2,6,..,38; done on the final stop cycle.
        tbl[0]  = '{0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{6, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{10, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{14, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{18, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{22, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{26, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{30, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{34, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{38, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{39, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{40, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{41, 1'b1, 1'b0, 1'b0};

        // Reset held 3 cycles with a word waiting
        push(1'b0, 8'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_tx", i), 32'(a_tx), 32'd1);
            chk($sformatf("rst%0d_busy", i), 32'(a_busy), 32'd0);
            chk($sformatf("rst%0d_read", i), 32'(a_read), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("first_pop_after_reset", 32'(a_read), 32'd1);

        // Single word 0x55, table-driven
        record(1'b0, 45);
        foreach (tbl[i]) begin
            chk($sformatf("w55_off%0d_tx", tbl[i].off), 32'(tr_tx[tbl[i].off]), 32'(tbl[i].tx));
            chk($sformatf("w55_off%0d_busy", tbl[i].off), 32'(tr_busy[tbl[i].off]), 32'(tbl[i].busy));
            chk($sformatf("w55_off%0d_done", tbl[i].off), 32'(tr_done[tbl[i].off]), 32'(tbl[i].done));
        end
        pops = 0;
        for (int i = 1; i < 45; i++) if (tr_rd[i] === 1'b1) pops++;
        chk("w55_extra_pops", 32'(pops), 32'd0);

        // Empty FIFO for 200 cycles
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (a_read !== 1'b0 || a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
            step();
        end
        chk("empty_idle_violations", 32'(bad), 32'd0);

        // Back-to-back 0xA5, 0x3C
        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
        wait_pop(1'b0, "b2b");
        record(1'b0, 90);
        chk("b2b_byte0", 32'(decode(0)), 32'hA5);
        chk("b2b_pop_gap", 32'(next_pop(1, 90)), 32'd41);
        chk("b2b_byte1", 32'(decode(41)), 32'h3C);
        chk("b2b_high_between", 32'(high_run(37, 90)), 32'd5);

        // Reset during data bit 3 of 0xFF, then the next word goes out intact
        push(1'b0, 8'hFF);
        push(1'b0, 8'h81);
        wait_pop(1'b0, "abort");
        for (int i = 0; i < 18; i++) step();
        chk("abort_busy_before", 32'(a_busy), 32'd1);
        reset = 1'b1;
        step();
        chk("abort_tx", 32'(a_tx), 32'd1);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_read_in_reset", 32'(a_read), 32'd0);
        reset = 1'b0;
        wait_pop(1'b0, "after_abort");
        record(1'b0, 45);
        chk("after_abort_byte", 32'(decode(0)), 32'h81);
        chk("after_abort_done", 32'(tr_done[40]), 32'd1);

        // Odd parity, two stop bits: 0x07 then 0x03
        push(1'b1, 8'h07);
        push(1'b1, 8'h03);
        wait_pop(1'b1, "par");
        record(1'b1, 100);
        chk("par_byte0", 32'(decode(0)), 32'h07);
        chk("par_bit0", 32'(tr_tx[38]), 32'd0);
        chk("par_stop_idle_run", 32'(high_run(41, 100)), 32'd9);
        chk("par_done_early", 32'(tr_done[47]), 32'd0);
        chk("par_done", 32'(tr_done[48]), 32'd1);
        chk("par_period", 32'(next_pop(1, 100)), 32'd49);
        chk("par_byte1", 32'(decode(49)), 32'h03);
        chk("par_bit1", 32'(tr_tx[49 + 38]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
